// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with occupancy flags, sticky error flags,
// synchronous flush, and a choice of registered or first-word-fall-through read.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        din,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic              empty_s;
    logic              full_s;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_word;

    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == DEPTH_C);

    // flush masks both requests so neither pointers, memory nor sticky flags move
    assign wr_accept = wr_en && !full_s  && !flush;
    assign rd_accept = rd_en && !empty_s && !flush;

    assign rd_word = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // a set condition in the same cycle as clr_err wins
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && full_s && !flush)  overflow_d  = 1'b1;
        if (rd_en && empty_s && !flush) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // storage is deliberately not reset; rst only gates the write strobe
    always_ff @(posedge clk) begin
        if (wr_accept && !rst) mem[wr_ptr_q] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty_s ? '0 : rd_word;
        end else begin : g_std
            logic [DATA_W-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (rd_accept) dout_d = rd_word;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) dout_q <= '0;
                else     dout_q <= dout_d;
            end

            assign dout = dout_q;
        end
    endgenerate

    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: one registered-read and one FWFT instance share stimulus
// and are checked against a queue-based reference model plus directed vectors.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] din = '0;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [7:0] dout_s, dout_f;
    logic       empty_s, full_s, ae_s, af_s, ovf_s, udf_s;
    logic       empty_f, full_f, ae_f, af_f, ovf_f, udf_f;
    logic [4:0] count_s, count_f;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .dout(dout_s), .empty(empty_s),
        .full(full_s), .almost_empty(ae_s), .almost_full(af_s), .count(count_s),
        .overflow(ovf_s), .underflow(udf_s)
    );

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .flush(flush), .clr_err(clr_err), .dout(dout_f), .empty(empty_f),
        .full(full_f), .almost_empty(ae_f), .almost_full(af_f), .count(count_f),
        .overflow(ovf_f), .underflow(udf_f)
    );

    // reference model: contents as a queue, registered dout, sticky flags
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_udf;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        int fw;
        n  = mq.size();
        fw = (n == 0) ? 0 : int'(mq[0]);
        chk("count_std", int'(count_s), n);
        chk("count_fwft", int'(count_f), n);
        chk("empty", int'(empty_s) + 2 * int'(empty_f), (n == 0) ? 3 : 0);
        chk("full", int'(full_s) + 2 * int'(full_f), (n == 16) ? 3 : 0);
        chk("almost_empty", int'(ae_s) + 2 * int'(ae_f), (n <= 2) ? 3 : 0);
        chk("almost_full", int'(af_s) + 2 * int'(af_f), (n >= 14) ? 3 : 0);
        chk("overflow", int'(ovf_s) + 2 * int'(ovf_f), m_ovf ? 3 : 0);
        chk("underflow", int'(udf_s) + 2 * int'(udf_f), m_udf ? 3 : 0);
        chk("dout_std", int'(dout_s), int'(m_dout));
        chk("dout_fwft", int'(dout_f), fw);
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r,
                              input logic fl, input logic ce);
        bit was_full;
        bit was_empty;
        was_full  = (mq.size() == 16);
        was_empty = (mq.size() == 0);
        if (ce) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (fl) begin
            mq.delete();
        end else begin
            if (w && was_full)  m_ovf = 1'b1;
            if (r && was_empty) m_udf = 1'b1;
            if (r && !was_empty) m_dout = mq.pop_front();
            if (w && !was_full)  mq.push_back(d);
        end
    endtask

    // drive at the falling edge, update model at the rising edge, check 1 time unit later
    task automatic cycle(input logic w, input logic [7:0] d, input logic r,
                         input logic fl, input logic ce);
        wr_en = w; din = d; rd_en = r; flush = fl; clr_err = ce;
        @(posedge clk);
        model_step(w, d, r, fl, ce);
        #1;
        check_model();
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
    endtask

    // asynchronous reset asserted between edges, with a write request held to prove it is ignored
    task automatic do_reset(input logic w_during);
        wr_en = w_during; din = 8'h5A; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        mq.delete();
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        #1;
        check_model();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] d;
        logic       rd;
        logic       fl;
        logic       ce;
        int         e_cnt;
        logic       e_udf;
        logic [7:0] e_d0;
        logic [7:0] e_d1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 8'hA5};
        tbl[1]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 1'b0, 8'h00, 8'hA5};
        tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'hA5, 8'h3C};
        tbl[3]  = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1, 1'b0, 8'h3C, 8'h77};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 8'h77, 8'h00};
        tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 8'h77, 8'h00};
        tbl[6]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1, 1'b1, 8'h77, 8'h11};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0, 8'h77, 8'h11};
        tbl[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h77, 8'h00};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 8'h77, 8'h00};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h77, 8'h00};

        mq.delete();
        m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        // directed table, including FWFT A5 visibility and set-wins-over-clear
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].fl, tbl[i].ce);
            chk("tbl_count", int'(count_s), tbl[i].e_cnt);
            chk("tbl_underflow", int'(udf_s), int'(tbl[i].e_udf));
            chk("tbl_dout_std", int'(dout_s), int'(tbl[i].e_d0));
            chk("tbl_dout_fwft", int'(dout_f), int'(tbl[i].e_d1));
        end

        // fill 0x00..0x0F, then one write too many
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_af", int'(af_s), (i + 1 >= 14) ? 1 : 0);
        end
        chk("fill_full", int'(full_s), 1);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("fill_ovf_count", int'(count_s), 16);
        chk("fill_ovf", int'(ovf_s), 1);

        // drain with registered read, then one read too many
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("drain_dout", int'(dout_s), i);
        end
        chk("drain_empty", int'(empty_s), 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("drain_udf", int'(udf_s), 1);
        chk("drain_hold", int'(dout_s), 8'h0F);

        // wrap: 10 in/out, then 12 in/out across the pointer wrap
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            chk("wrap_order", int'(dout_s), 8'h80 + i);
        end
        chk("wrap_count", int'(count_s), 0);

        // simultaneous read+write at count 5 and at full
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hC5, 1'b1, 1'b0, 1'b0);
        chk("both_mid_count", int'(count_s), 5);
        for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        chk("both_full_count", int'(count_s), 15);
        chk("both_full_ovf", int'(ovf_s), 1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("clr_ovf", int'(ovf_s), 0);

        // flush at count 9 with a concurrent write, then reset mid-fill
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        chk("flush_count", int'(count_s), 0);
        chk("flush_empty", int'(empty_s), 1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        do_reset(1'b1);
        chk("rst_count", int'(count_s), 0);

        // randomised traffic in write-heavy, balanced and read-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int wb;
            wb = ((i / 400) % 3 == 0) ? 75 : (((i / 400) % 3 == 1) ? 50 : 25);
            cycle(($urandom_range(99) < wb) ? 1'b1 : 1'b0, 8'($urandom),
                  ($urandom_range(99) < (100 - wb)) ? 1'b1 : 1'b0,
                  ($urandom_range(63) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(15) == 0) ? 1'b1 : 1'b0);
            if (i == 1500) do_reset(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
